ll_window_acc: RTL and testbench
================================

# ll_window_acc

Sliding-window line-length accumulator that sits directly downstream of the line-length difference stage. It consumes the per-sample absolute differences and keeps a running sum over the last N = 2^WIN_LOG2 valid samples using a circular buffer. Once the window is full it produces one windowed line-length value per input sample. A thresholded, debounced detect flag drives the feature/decision logic.

## Interface
- IN_WIDTH, 33: width of incoming magnitude; matches the upstream output width (input_width+1).
- WIN_LOG2, 6: log2 of window length N (N = 64 by default); legal range 1..10.
- DET_COUNT, 4: number of consecutive above-threshold outputs required to assert detect; legal range 1..255.
- SUM_WIDTH, IN_WIDTH+WIN_LOG2: derived; width of sum and thr.

- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous flush, active-high; same effect as rst, lower priority.
- din_valid  in  1  active-high qualifier for din.
- din  in  IN_WIDTH  sample magnitude; treated as unsigned, MSB always 0 from upstream.
- thr  in  SUM_WIDTH  detection threshold, unsigned; sampled every cycle, quasi-static.
- sum  out  SUM_WIDTH  windowed line length, registered.
- sum_valid  out  1  one-cycle pulse per new sum.
- window_full  out  1  high in RUN state.
- detect  out  1  debounced threshold flag, registered.

## Operation
- Storage: N-entry circular buffer of IN_WIDTH words, with write pointer wr_ptr (WIN_LOG2 bits, wraps N-1→0) and fill counter fill_cnt (WIN_LOG2+1 bits).
- Buffer contents are not reset. An entry is never subtracted before it has been written since the last rst/clr.
- States:
  - FILL (reset state): each valid sample is written at wr_ptr, wr_ptr++, fill_cnt++, and sum_next = sum + din.
  - FILL→RUN: on the valid sample that brings fill_cnt to N.
  - RUN: buf[wr_ptr] holds the oldest sample. Each valid sample does sum_next = sum + din − buf[wr_ptr], then overwrites buf[wr_ptr] and increments wr_ptr. RUN persists until rst/clr.
- sum_valid is asserted only for the sample that completes the window (the FILL→RUN transition) and for every valid sample in RUN. During FILL, sum updates internally but sum_valid stays 0.
- Arithmetic is unsigned, SUM_WIDTH bits, and cannot overflow (max N·(2^IN_WIDTH−1)). The subtraction never underflows because the subtracted word is always part of the current sum.
- Detect logic:
  - Saturating counter det_cnt (8 bits).
  - On each sum_valid: if sum_next > thr (strict), det_cnt = min(det_cnt+1, DET_COUNT); otherwise det_cnt = 0.
  - detect = (det_cnt_next == DET_COUNT), registered in the same edge as sum.
  - detect changes only on sum_valid cycles.
- din_valid low: all state and outputs hold, except sum_valid, which is 0.
- rst or clr: state=FILL, wr_ptr=0, fill_cnt=0, sum=0, det_cnt=0, sum_valid=0, window_full=0, detect=0.
- clr together with din_valid: clr wins and the sample is dropped. rst overrides clr.

## Timing
- Latency: din/din_valid sampled at edge k → sum, sum_valid, detect, window_full are valid after edge k (visible in cycle k+1). One cycle, no stall.
- Throughput is one sample per clock. Back-to-back din_valid is supported, and so are arbitrary gaps.
- The buffer read of the oldest entry is combinational from registers, so read-before-write occurs within the same cycle.
- window_full rises in the same cycle as the first sum_valid.
- Reset values of all outputs are 0. They hold 0 through the first rising edge after rst deasserts.
- No backpressure: the downstream consumer must accept every sum_valid pulse.

## Test plan
Configuration for scenarios 2–5: WIN_LOG2=2 (N=4), DET_COUNT=2.
1. Reset: hold rst 3 cycles with din_valid=1, din=7 → sum=0, sum_valid=0, window_full=0, detect=0 throughout and on the cycle after release.
2. Fill and slide: valid din 1,2,3,4 → no sum_valid for the first three, then sum=10, sum_valid=1, window_full=1. Next 5 → sum=14. Next 0 → sum=12.
3. Gaps: insert 3 idle cycles between samples in scenario 2 → identical sum sequence; sum_valid=0 and sum held during idle cycles.
4. Detect: thr=11 with the scenario 2 stream → detect stays 0 through sum=10 and goes 0 at sum=14 (det_cnt=1). At sum=12, detect=1. Next din 0 → sum=9, detect=0.
5. clr mid-run: clr=1 with din_valid=1, din=9 in RUN → sum=0, window_full=0, sum_valid=0, sample dropped. Refill with 1,1,1,1 → sum=4 on the 4th sample.
6. Width extremes (defaults): feed 64 samples of 2^32−1 → first sum = 64·(2^32−1) exact. A following sample of 0 → sum = 63·(2^32−1). No wrap at wr_ptr 63→0.

Source files
------------

// File: rtl/ll_window_acc.sv
// ll_window_acc
// Sliding-window line-length accumulator. Keeps a running sum of the last
// N = 2**WIN_LOG2 valid input magnitudes in a circular buffer. Once the window
// is full it emits one windowed sum per valid sample. It also produces a
// debounced detect flag that is set after DET_COUNT consecutive sums exceed thr.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   clr          synchronous active-high flush (same effect as rst, lower priority)
//   din_valid    qualifier for din
//   din          unsigned sample magnitude (IN_WIDTH bits)
//   thr          unsigned detection threshold (SUM_WIDTH bits), quasi-static
//   sum          windowed line length, registered
//   sum_valid    one-cycle pulse per new windowed sum
//   window_full  high once the window has been filled (RUN state)
//   detect       debounced threshold flag, registered
module ll_window_acc #(
    parameter int IN_WIDTH  = 33,
    parameter int WIN_LOG2  = 6,
    parameter int DET_COUNT = 4,
    parameter int SUM_WIDTH = IN_WIDTH + WIN_LOG2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 din_valid,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic [SUM_WIDTH-1:0] thr,
    output logic [SUM_WIDTH-1:0] sum,
    output logic                 sum_valid,
    output logic                 window_full,
    output logic                 detect
);

    localparam int N = 1 << WIN_LOG2;
    localparam logic [7:0]        DET_MAX   = 8'(DET_COUNT);
    localparam logic [WIN_LOG2:0] FILL_LAST = (WIN_LOG2+1)'(N - 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t              state;
    logic [IN_WIDTH-1:0] mem [N];
    logic [WIN_LOG2-1:0] wr_ptr;
    logic [WIN_LOG2:0]   fill_cnt;
    logic [7:0]          det_cnt;

    logic [IN_WIDTH-1:0]  oldest;
    logic [SUM_WIDTH-1:0] sum_next;
    logic                 fill_done;
    logic                 out_fire;
    logic [7:0]           det_cnt_next;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        if (c >= DET_MAX) return DET_MAX;
        return c + 8'd1;
    endfunction

    // The oldest sample is read combinationally so it can be subtracted in
    // the same cycle that the new sample overwrites its slot.
    always_comb begin
        oldest       = mem[wr_ptr];
        fill_done    = (state == FILL) && (fill_cnt == FILL_LAST);
        out_fire     = (state == RUN) || fill_done;
        sum_next     = sum + SUM_WIDTH'(din);
        if (state == RUN)
            sum_next = sum_next - SUM_WIDTH'(oldest);
        det_cnt_next = (sum_next > thr) ? sat_inc(det_cnt) : 8'd0;
    end

    // The buffer storage is not reset. The fill counter makes sure that no
    // stale entry is ever subtracted.
    always_ff @(posedge clk) begin
        if (din_valid && !rst && !clr)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state       <= FILL;
            wr_ptr      <= '0;
            fill_cnt    <= '0;
            sum         <= '0;
            det_cnt     <= '0;
            sum_valid   <= 1'b0;
            window_full <= 1'b0;
            detect      <= 1'b0;
        end else if (din_valid) begin
            wr_ptr    <= wr_ptr + 1'b1;
            sum       <= sum_next;
            sum_valid <= out_fire;
            if (state == FILL)
                fill_cnt <= fill_cnt + 1'b1;
            if (fill_done) begin
                state       <= RUN;
                window_full <= 1'b1;
            end
            if (out_fire) begin
                det_cnt <= det_cnt_next;
                detect  <= (det_cnt_next == DET_MAX);
            end
        end else begin
            sum_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ll_window_acc.sv
// Testbench for ll_window_acc.
// The small instance (N=4, DET_COUNT=2) runs directed scenarios and random
// traffic. It is checked against a queue-based window model.
// The default-parameter instance is used to check the width extremes.
module tb_ll_window_acc;

    localparam int SIN  = 33;
    localparam int SWL  = 2;
    localparam int SN   = 4;
    localparam int SDET = 2;
    localparam int SSW  = SIN + SWL;
    localparam int DSW  = 33 + 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // small instance
    logic           s_clr, s_valid;
    logic [SIN-1:0] s_din;
    logic [SSW-1:0] s_thr, s_sum;
    logic           s_sv, s_wf, s_det;

    // default instance
    logic           d_clr, d_valid;
    logic [32:0]    d_din;
    logic [DSW-1:0] d_thr, d_sum;
    logic           d_sv, d_wf, d_det;

    ll_window_acc #(.IN_WIDTH(SIN), .WIN_LOG2(SWL), .DET_COUNT(SDET)) dut_s (
        .clk(clk), .rst(rst), .clr(s_clr), .din_valid(s_valid), .din(s_din),
        .thr(s_thr), .sum(s_sum), .sum_valid(s_sv), .window_full(s_wf),
        .detect(s_det)
    );

    ll_window_acc dut_d (
        .clk(clk), .rst(rst), .clr(d_clr), .din_valid(d_valid), .din(d_din),
        .thr(d_thr), .sum(d_sum), .sum_valid(d_sv), .window_full(d_wf),
        .detect(d_det)
    );

    int tests = 0;
    int fails = 0;

    // reference model state: samples currently in the window
    logic [63:0] q[$];
    int          total;
    int          run_len;
    logic [63:0] exp_sum;
    logic        exp_sv, exp_wf, exp_det;

    task automatic model_flush();
        q.delete();
        total   = 0;
        run_len = 0;
        exp_sum = '0;
        exp_sv  = 1'b0;
        exp_wf  = 1'b0;
        exp_det = 1'b0;
    endtask

    task automatic model_update(input logic r, input logic c, input logic v,
                                input logic [63:0] d, input logic [63:0] t);
        if (r || c) begin
            model_flush();
        end else begin
            exp_sv = 1'b0;
            if (v) begin
                q.push_back(d);
                if (q.size() > SN) void'(q.pop_front());
                total++;
                exp_sum = '0;
                foreach (q[i]) exp_sum += q[i];
                if (total >= SN) begin
                    exp_sv = 1'b1;
                    if (exp_sum > t) run_len++;
                    else run_len = 0;
                    exp_det = (run_len >= SDET);
                end
            end
            exp_wf = (total >= SN);
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_small();
        check("sum", 64'(s_sum), exp_sum);
        check("sum_valid", 64'(s_sv), 64'(exp_sv));
        check("window_full", 64'(s_wf), 64'(exp_wf));
        check("detect", 64'(s_det), 64'(exp_det));
    endtask

    // One clock of the small instance: drive, clock, update model, compare.
    task automatic step(input logic r, input logic c, input logic v,
                        input logic [SIN-1:0] d);
        @(negedge clk);
        rst = r; s_clr = c; s_valid = v; s_din = d;
        @(posedge clk);
        #1;
        model_update(r, c, v, 64'(d), 64'(s_thr));
        check_small();
    endtask

    task automatic dstep(input logic v, input logic [32:0] d);
        @(negedge clk);
        d_valid = v; d_din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DSW-1:0] full_w;
        logic [32:0]    maxin;
        rst = 1'b1; s_clr = 1'b0; s_valid = 1'b0; s_din = '0; s_thr = '1;
        d_clr = 1'b0; d_valid = 1'b0; d_din = '0; d_thr = '1;
        model_flush();

        // Reset held with valid traffic present.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 33'd7);
        step(1'b0, 1'b0, 1'b0, 33'd0);
        check("reset_sum_d", 64'(d_sum), 64'd0);
        check("reset_wf_d", 64'(d_wf), 64'd0);

        // Fill, slide and detect with thr = 11.
        s_thr = SSW'(11);
        step(0, 0, 1, 33'd1);
        step(0, 0, 1, 33'd2);
        step(0, 0, 1, 33'd3);
        step(0, 0, 1, 33'd4);
        check("first_sum", 64'(s_sum), 64'd10);
        step(0, 0, 1, 33'd5);
        check("slide14", 64'(s_sum), 64'd14);
        step(0, 0, 1, 33'd0);
        check("slide12", 64'(s_sum), 64'd12);
        check("detect_on", 64'(s_det), 64'd1);
        step(0, 0, 1, 33'd0);
        check("slide9", 64'(s_sum), 64'd9);
        check("detect_off", 64'(s_det), 64'd0);

        // Same stream with 3 idle cycles between samples.
        step(0, 1, 0, 33'd0);
        for (int i = 0; i < 7; i++) begin
            logic [SIN-1:0] vals [7];
            vals = '{33'd1, 33'd2, 33'd3, 33'd4, 33'd5, 33'd0, 33'd0};
            step(0, 0, 1, vals[i]);
            for (int g = 0; g < 3; g++) step(0, 0, 0, 33'd0);
        end
        check("gap_sum9", 64'(s_sum), 64'd9);

        // A flush that arrives together with a valid sample drops that sample.
        step(0, 1, 1, 33'd9);
        check("clr_sum", 64'(s_sum), 64'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 33'd1);
        check("refill_sum", 64'(s_sum), 64'd4);

        // Random traffic, mixing small values with full-width values.
        for (int i = 0; i < 400; i++) begin
            logic           v, c;
            logic [SIN-1:0] d;
            if (i % 50 == 0) begin
                if (i % 100 == 0) s_thr = SSW'($urandom_range(0, 40));
                else s_thr = {1'b0, 2'($urandom_range(0, 3)), 32'($urandom)};
            end
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 60) == 0);
            if (i % 100 < 50) d = SIN'($urandom_range(0, 15));
            else d = {1'b0, 32'($urandom)};
            step(($urandom_range(0, 150) == 0), c, v, d);
        end

        // Width extremes on the default instance.
        maxin = {1'b0, 32'hFFFF_FFFF};
        for (int i = 0; i < 63; i++) begin
            dstep(1'b1, maxin);
            if (i == 62) check("d_no_sv_fill", 64'(d_sv), 64'd0);
        end
        dstep(1'b1, maxin);
        full_w = DSW'(64) * DSW'(maxin);
        check("d_full_sum", 64'(d_sum), 64'(full_w));
        check("d_full_sv", 64'(d_sv), 64'd1);
        check("d_full_wf", 64'(d_wf), 64'd1);
        dstep(1'b1, 33'd0);
        check("d_sum63", 64'(d_sum), 64'(DSW'(63) * DSW'(maxin)));
        dstep(1'b1, 33'd0);
        check("d_sum62", 64'(d_sum), 64'(DSW'(62) * DSW'(maxin)));
        dstep(1'b0, 33'd0);
        check("d_idle_sv", 64'(d_sv), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
